// File: rtl/id_scoreboard_pkg.sv
// ============================================================================
// id_scoreboard_pkg : shared constants for the ID-stage register scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

package id_scoreboard_pkg;
  localparam int SB_CNT_W = 2;
  localparam int NUM_GPR  = 32;
  localparam int GPR_AW   = $clog2(NUM_GPR);

  typedef logic [GPR_AW-1:0] gpr_addr_t;

  // True when addr selects tracked register idx; r0 is never a hit.
  function automatic logic gpr_hit(input gpr_addr_t addr, input int idx);
    return (addr != '0) && (addr == GPR_AW'(idx));
  endfunction
endpackage

`default_nettype wire

// File: rtl/id_scoreboard_if.sv
// ============================================================================
// id_scoreboard_if : ID-stage / scoreboard handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface id_scoreboard_if;
  import id_scoreboard_pkg::*;

  logic      id_valid;
  logic      src1_en;
  gpr_addr_t src1_addr;
  logic      src2_en;
  gpr_addr_t src2_addr;
  logic      id_issue;
  logic      id_regW;
  gpr_addr_t id_regWAddr;
  logic      wb_retire;
  gpr_addr_t wb_regWAddr;
  logic      flush;
  logic      id_stall;
  logic      sb_busy;
  logic      sb_err;

  modport master (
    output id_valid, src1_en, src1_addr, src2_en, src2_addr,
    output id_issue, id_regW, id_regWAddr, wb_retire, wb_regWAddr, flush,
    input  id_stall, sb_busy, sb_err
  );

  modport slave (
    input  id_valid, src1_en, src1_addr, src2_en, src2_addr,
    input  id_issue, id_regW, id_regWAddr, wb_retire, wb_regWAddr, flush,
    output id_stall, sb_busy, sb_err
  );
endinterface

`default_nettype wire

// File: rtl/sb_cnt_cell.sv
// ============================================================================
// sb_cnt_cell : saturating up/down pending-writer counter for one register
// Rev 1.0
// ============================================================================
`default_nettype none

module sb_cnt_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over inc/dec, so a flushed cycle never reports an error.
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) err_o = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

`default_nettype wire

// File: rtl/id_scoreboard.sv
// ============================================================================
// id_scoreboard : per-GPR in-flight writer tracking and ID issue interlock
// Rev 1.0
// ============================================================================
`default_nettype none

module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  id_scoreboard_if.slave sb
);
  logic [CNT_W-1:0]   cnt [NUM_GPR];
  logic [NUM_GPR-1:1] err_vec;
  logic               inc_en;
  logic               src1_hit;
  logic               src2_hit;
  logic               busy;
  logic               err_q, err_d;

  assign inc_en = sb.id_issue & sb.id_regW;
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_GPR; r++) begin : g_cell
    logic inc_r;
    logic dec_r;
    assign inc_r = inc_en       & gpr_hit(sb.id_regWAddr, r);
    assign dec_r = sb.wb_retire & gpr_hit(sb.wb_regWAddr, r);

    sb_cnt_cell #(.CNT_W(CNT_W)) u_cell (
      .clk   (clk),
      .reset (reset),
      .inc_i (inc_r),
      .dec_i (dec_r),
      .clr_i (sb.flush),
      .cnt_o (cnt[r]),
      .err_o (err_vec[r])
    );
  end

  // No writeback bypass: a retiring writer still blocks its readers this cycle.
  assign src1_hit = sb.src1_en & (sb.src1_addr != '0) & (cnt[sb.src1_addr] != '0);
  assign src2_hit = sb.src2_en & (sb.src2_addr != '0) & (cnt[sb.src2_addr] != '0);

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NUM_GPR; r++) busy = busy | (|cnt[r]);
  end

  assign err_d = err_q | (|err_vec);

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign sb.id_stall = sb.id_valid & (src1_hit | src2_hit);
  assign sb.sb_busy  = busy;
  assign sb.sb_err   = err_q;
endmodule

`default_nettype wire
